// File: rtl/uart_pkg.sv
// Shared types and helpers for the byte-level UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

    localparam int unsigned UART_DATA_BITS = 8;

    // Rounded clocks-per-bit divider.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting for the transmitter; head is read combinationally.
module uart_tx_fifo #(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (FIFO_AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (FIFO_AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 (or 8N2) UART transmitter with valid/ready byte input and registered serial output.
// Define UART_TX_FIFO_EN to queue bytes in a uart_tx_fifo instead of a single holding register.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 27_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned FIFO_AW   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      uart_tx,
    output logic                      busy
);

    localparam int unsigned DIV      = calc_div(CLK_HZ, BAUD);
    localparam int unsigned STOP_CYC = STOP_BITS * DIV;
    localparam int unsigned CNT_W    = (STOP_CYC > 2) ? $clog2(STOP_CYC) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYC - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_byte_tx: CLK_HZ/BAUD divider must be at least 2");
    end
    if (FIFO_AW < 1) begin : g_bad_fifo_aw
        $error("uart_byte_tx: FIFO_AW must be at least 1");
    end

    logic                      q_push;
    logic                      q_pop;
    logic                      q_full;
    logic                      q_empty;
    logic [UART_DATA_BITS-1:0] q_dout;

    uart_tx_state_e            state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      uart_tx_q;
    logic                      stop_last;

    assign tx_ready = !q_full;
    assign q_push   = tx_valid && !q_full;

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(
        .FIFO_AW (FIFO_AW),
        .WIDTH   (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .din   (tx_data),
        .pop   (q_pop),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );
`else
    logic [UART_DATA_BITS-1:0] hold_q;
    logic                      hold_full_q;

    // Push needs !full and pop needs full, so the two never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (q_push) begin
            hold_q      <= tx_data;
            hold_full_q <= 1'b1;
        end else if (q_pop) begin
            hold_full_q <= 1'b0;
        end
    end

    assign q_dout  = hold_q;
    assign q_full  = hold_full_q;
    assign q_empty = !hold_full_q;
`endif

    always_comb begin
        stop_last = (state_q == STOP) && (cnt_q == STOP_LAST);
        q_pop     = !q_empty && ((state_q == IDLE) || stop_last);
    end

    // The line register follows state one clock behind, giving accept -> pop -> drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            unique case (state_q)
                START:   uart_tx_q <= 1'b0;
                DATA:    uart_tx_q <= shift_q[0];
                default: uart_tx_q <= 1'b1;
            endcase

            unique case (state_q)
                IDLE: begin
                    if (q_pop) begin
                        shift_q   <= q_dout;
                        bit_idx_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == BIT_LAST) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (stop_last) begin
                        cnt_q <= '0;
                        if (q_pop) begin
                            shift_q   <= q_dout;
                            bit_idx_q <= '0;
                            state_q   <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign uart_tx = uart_tx_q;
    assign busy    = (state_q != IDLE) || !q_empty;

endmodule
